// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bus of fetch_redirect_unit.
// The unit uses the slave modport. The surrounding pipeline, memory or
// testbench uses the master modport.
//   redirect/redirect_pc : taken branch/jump and its target, from execute
//   stall                : decode hazard stall
//   imem_q               : synchronous imem read data (word at pc_q)
//   imem_addr            : imem address for the next read
//   pc_plus_one          : pc_q+1, default next-PC for execute
//   fd_pc_out/ir/valid   : F/D pipeline latch
//   flush_dx             : load nop into the D/X latch
//   booted               : unit has left its boot phase
//   redirect_cnt/squash_cnt : saturating performance counters
interface fetch_redirect_unit_if #(
  parameter int IMEM_AW = 12,
  parameter int CNT_W   = 16
);
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               stall;
  logic [31:0]        imem_q;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc_plus_one;
  logic [31:0]        fd_pc_out;
  logic [31:0]        fd_ir_out;
  logic               fd_valid;
  logic               flush_dx;
  logic               booted;
  logic [CNT_W-1:0]   redirect_cnt;
  logic [CNT_W-1:0]   squash_cnt;

  modport slave (
    input  redirect, redirect_pc, stall, imem_q,
    output imem_addr, pc_plus_one, fd_pc_out, fd_ir_out, fd_valid,
           flush_dx, booted, redirect_cnt, squash_cnt
  );

  modport master (
    output redirect, redirect_pc, stall, imem_q,
    input  imem_addr, pc_plus_one, fd_pc_out, fd_ir_out, fd_valid,
           flush_dx, booted, redirect_cnt, squash_cnt
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the fetch PC, the imem address and the F/D latch.
// It applies execute-stage redirects, squashes wrong-path words, raises the
// D/X flush and keeps redirect/squash counters.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : fetch_redirect_unit_if.slave (see the interface header)
module fetch_redirect_unit #(
  parameter int IMEM_AW     = 12,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  fetch_redirect_unit_if.slave  bus
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       boot_cnt_q;
  logic [31:0]      pc_q;
  logic [31:0]      next_fetch;
  logic [31:0]      fd_pc_q, fd_ir_q;
  logic             fd_valid_q;
  logic [CNT_W-1:0] redirect_cnt_q, squash_cnt_q;
  logic             run;
  logic             take_redirect;

  assign run           = (state_q == RUN);
  assign take_redirect = bus.redirect & run;

  // Add a small increment and clamp at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && boot_cnt_q == 4'(BOOT_CYCLES - 1))
      state_d = RUN;
  end

  // Next fetch address. A redirect outranks a stall, so a stall raised in
  // the same cycle as a redirect is dropped.
  always_comb begin
    next_fetch = pc_q + 32'd1;
    if (take_redirect)
      next_fetch = bus.redirect_pc;
    else if (!run)
      next_fetch = 32'd0;
    else if (bus.stall)
      next_fetch = pc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= 4'd0;
      pc_q       <= 32'd0;
    end else begin
      state_q <= state_d;
      if (!run)
        boot_cnt_q <= boot_cnt_q + 4'd1;
      pc_q <= next_fetch;
    end
  end

  // F/D latch and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fd_pc_q        <= 32'd0;
      fd_ir_q        <= 32'd0;
      fd_valid_q     <= 1'b0;
      redirect_cnt_q <= '0;
      squash_cnt_q   <= '0;
    end else if (!run) begin
      fd_pc_q    <= 32'd0;
      fd_ir_q    <= 32'd0;
      fd_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      // The current imem word is wrong-path, as is any valid F/D entry.
      fd_pc_q        <= 32'd0;
      fd_ir_q        <= 32'd0;
      fd_valid_q     <= 1'b0;
      redirect_cnt_q <= sat_add(redirect_cnt_q, 2'd1);
      squash_cnt_q   <= sat_add(squash_cnt_q, {1'b0, fd_valid_q} + 2'd1);
    end else if (!bus.stall) begin
      fd_pc_q    <= pc_q + 32'd1;
      fd_ir_q    <= bus.imem_q;
      fd_valid_q <= 1'b1;
    end
  end

  assign bus.imem_addr    = next_fetch[IMEM_AW-1:0];
  assign bus.pc_plus_one  = pc_q + 32'd1;
  assign bus.fd_pc_out    = fd_pc_q;
  assign bus.fd_ir_out    = fd_ir_q;
  assign bus.fd_valid     = fd_valid_q;
  assign bus.flush_dx     = take_redirect;
  assign bus.booted       = run;
  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.squash_cnt   = squash_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed testbench for fetch_redirect_unit. It uses a synchronous imem
// model with mem[i] = {16'hC0DE, i}. The counters are built 4 bits wide so
// that saturation can be reached in a few cycles.
module tb_fetch_redirect_unit;

  localparam int IMEM_AW = 12;
  localparam int CNT_W   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] mem [0:(1<<IMEM_AW)-1];

  fetch_redirect_unit_if #(.IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) bus ();

  fetch_redirect_unit #(.IMEM_AW(IMEM_AW), .BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) bus.imem_q <= mem[bus.imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_fd(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                          input logic v);
    check({tag, ".fd_pc"}, bus.fd_pc_out, pc);
    check({tag, ".fd_ir"}, bus.fd_ir_out, ir);
    check({tag, ".fd_valid"}, {31'd0, bus.fd_valid}, {31'd0, v});
  endtask

  initial begin
    for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = {16'hC0DE, 16'(i)};
    bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.stall = 1'b0;

    // Reset state
    step(); step();
    check_fd("rst", 32'd0, 32'd0, 1'b0);
    check("rst.booted", {31'd0, bus.booted}, 32'd0);
    check("rst.imem_addr", {20'd0, bus.imem_addr}, 32'd0);
    check("rst.redirect_cnt", {28'd0, bus.redirect_cnt}, 32'd0);
    check("rst.squash_cnt", {28'd0, bus.squash_cnt}, 32'd0);
    $display("[TB] reset state checked");

    // 1: boot then sequential fetch
    reset = 1'b1;                                   // cycle 0
    step(); check("boot.c1.booted", {31'd0, bus.booted}, 32'd0);
    step(); check("boot.c2.booted", {31'd0, bus.booted}, 32'd1);
    check("boot.c2.imem_addr", {20'd0, bus.imem_addr}, 32'd1);
    check_fd("boot.c2", 32'd0, 32'd0, 1'b0);
    step(); check_fd("seq1", 32'd1, 32'hC0DE0000, 1'b1);
    step(); check_fd("seq2", 32'd2, 32'hC0DE0001, 1'b1);
    $display("[TB] boot and sequential fetch");

    // 2: stall three cycles holding (2,B)
    bus.stall = 1'b1; #1;
    check("stall.imem_addr0", {20'd0, bus.imem_addr}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      check_fd("stall.hold", 32'd2, 32'hC0DE0001, 1'b1);
      check("stall.imem_addr", {20'd0, bus.imem_addr}, 32'd2);
    end
    bus.stall = 1'b0;
    step(); check_fd("stall.release", 32'd3, 32'hC0DE0002, 1'b1);
    $display("[TB] stall hold and release");

    // 3: redirect to 0x40
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40; #1;
    check("redir.flush_dx", {31'd0, bus.flush_dx}, 32'd1);
    check("redir.imem_addr", {20'd0, bus.imem_addr}, 32'h40);
    step(); bus.redirect = 1'b0; #1;
    check_fd("redir.nop", 32'd0, 32'd0, 1'b0);
    check("redir.flush_off", {31'd0, bus.flush_dx}, 32'd0);
    check("redir.redirect_cnt", {28'd0, bus.redirect_cnt}, 32'd1);
    check("redir.squash_cnt", {28'd0, bus.squash_cnt}, 32'd2);
    step(); check_fd("redir.target", 32'h41, 32'hC0DE0040, 1'b1);
    $display("[TB] redirect to 0x40");

    // 4: redirect and stall together
    bus.redirect = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 32'h80; #1;
    check("rs.imem_addr", {20'd0, bus.imem_addr}, 32'h80);
    step(); bus.redirect = 1'b0; bus.stall = 1'b0;
    check("rs.pc_plus_one", bus.pc_plus_one, 32'h81);
    check("rs.fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    check("rs.redirect_cnt", {28'd0, bus.redirect_cnt}, 32'd2);
    check("rs.squash_cnt", {28'd0, bus.squash_cnt}, 32'd4);
    step(); check_fd("rs.target", 32'h81, 32'hC0DE0080, 1'b1);
    $display("[TB] redirect with stall");

    // 5: back-to-back redirects 0x10 then 0x20
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10;
    step(); bus.redirect_pc = 32'h20;
    check("b2b.fd_valid1", {31'd0, bus.fd_valid}, 32'd0);
    step(); bus.redirect = 1'b0;
    check("b2b.fd_valid2", {31'd0, bus.fd_valid}, 32'd0);
    check("b2b.pc_plus_one", bus.pc_plus_one, 32'h21);
    check("b2b.redirect_cnt", {28'd0, bus.redirect_cnt}, 32'd4);
    check("b2b.squash_cnt", {28'd0, bus.squash_cnt}, 32'd7);
    step(); check_fd("b2b.target", 32'h21, 32'hC0DE0020, 1'b1);
    $display("[TB] back-to-back redirects");

    // 6: asynchronous reset mid-stream, then counter saturation
    step();
    bus.redirect = 1'b1; reset = 1'b0; #1;
    check_fd("areset", 32'd0, 32'd0, 1'b0);
    check("areset.booted", {31'd0, bus.booted}, 32'd0);
    check("areset.flush_dx", {31'd0, bus.flush_dx}, 32'd0);
    check("areset.imem_addr", {20'd0, bus.imem_addr}, 32'd0);
    check("areset.pc_plus_one", bus.pc_plus_one, 32'd1);
    check("areset.redirect_cnt", {28'd0, bus.redirect_cnt}, 32'd0);
    check("areset.squash_cnt", {28'd0, bus.squash_cnt}, 32'd0);
    step();
    reset = 1'b1;
    step(); step();                                 // booted, redirect still high
    check("sat.booted", {31'd0, bus.booted}, 32'd1);
    for (int k = 0; k < 15; k++) step();
    check("sat.redirect_cnt15", {28'd0, bus.redirect_cnt}, 32'hF);
    check("sat.squash_cnt15", {28'd0, bus.squash_cnt}, 32'hF);
    step();
    check("sat.redirect_cnt_hold", {28'd0, bus.redirect_cnt}, 32'hF);
    check("sat.squash_cnt_hold", {28'd0, bus.squash_cnt}, 32'hF);
    bus.redirect = 1'b0;
    $display("[TB] async reset and saturation");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
Owns the architectural fetch PC, the instruction-memory address, and the F/D pipeline latch. It consumes the redirect request (branch_or_jump_taken, pc_next) that the execute-stage next-PC logic produces, and squashes wrong-path instructions. It issues a D/X flush and keeps redirect/squash performance counters. It sits between the synchronous instruction memory and the decode stage, and is the fetch-side end of the execute-stage redirect interface.

Parameters:
IMEM_AW, 12, instruction-memory word-address width; imem_addr = low IMEM_AW bits of the fetch address.
BOOT_CYCLES, 2, cycles after reset release before fetched data is treated as valid (1..15).
CNT_W, 16, width of the saturating performance counters.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low; asserted (0) forces the reset state immediately.
redirect  input  1  branch_or_jump_taken from execute-stage next-PC logic.
redirect_pc  input  32  target PC, valid when redirect=1.
stall  input  1  decode hazard stall; hold PC and F/D.
imem_q  input  32  instruction word for address pc_q, 1-cycle synchronous read.
imem_addr  output  IMEM_AW  address presented to imem this cycle (combinational).
pc_plus_one  output  32  pc_q+1; feeds the default next-PC input of the execute-stage logic.
fd_pc_out  output  32  F/D latch: (PC of instruction)+1.
fd_ir_out  output  32  F/D latch: instruction; nop = 32'h0.
fd_valid  output  1  F/D holds a real instruction.
flush_dx  output  1  combinational; =redirect, tells D/X latch to load nop.
booted  output  1  1 once state=RUN.
redirect_cnt  output  CNT_W  number of cycles with redirect=1 in RUN, saturating.
squash_cnt  output  CNT_W  number of valid F/D entries or imem words discarded by redirect, saturating.

Behaviour:
- State: pc_q[31:0], F/D latch, FSM {BOOT, RUN}, boot counter, two counters.
- Reset (reset=0, async): pc_q=0, fd_pc_out=0, fd_ir_out=0, fd_valid=0, FSM=BOOT, boot counter=0, counters=0, booted=0. imem_addr=0 while in reset.
- Invariant: imem_q in any cycle is the word at pc_q; pc_q <= next_fetch each edge.
- next_fetch, combinational, priority high to low:
  - redirect & RUN -> redirect_pc.
  - BOOT -> 0.
  - stall -> pc_q.
  - else -> pc_q+1.
- imem_addr = next_fetch[IMEM_AW-1:0]. Arithmetic is 32-bit, wrapping; 32'hFFFFFFFF+1=0.
- BOOT:
  - Hold pc_q=0; F/D loads nop (fd_valid=0); redirect and stall are ignored.
  - Boot counter increments each cycle; on reaching BOOT_CYCLES-1 go to RUN.
  - Entering RUN, pc_q=0 and imem_q is the word at address 0.
- RUN, F/D update each edge:
  - redirect=1: F/D <= nop, fd_valid=0. squash_cnt += fd_valid(old) + 1, because the current imem_q is wrong-path. redirect_cnt += 1. Both saturate at all-ones.
  - else stall=1: F/D holds; pc_q holds.
  - else: fd_pc_out <= pc_q+1, fd_ir_out <= imem_q, fd_valid <= 1.
- Redirect and stall together: redirect wins, and the stall is dropped for that cycle.
- Back-to-back redirects: each cycle squashes again and counts again; the last target wins.
- Redirect latency:
  - Cycle t: redirect=1, imem_addr=target.
  - t+1: pc_q=target, imem_q=target word.
  - t+2: F/D holds the target instruction (absent stall).
- flush_dx = redirect & (FSM==RUN).
- Reset mid-operation: asynchronous return to the reset state. Counters clear, and any redirect in progress is lost.
- Counters are read-only and saturate; they never wrap.

Test Plan:
1. Reset release, BOOT_CYCLES=2, imem[0..3]=A,B,C,D, no stall/redirect -> booted=1 on cycle 2. F/D then carries (1,A), (2,B), (3,C) on successive cycles; fd_valid=1 throughout.
2. Stall for 3 cycles while F/D=(2,B) -> F/D stays (2,B) and imem_addr stays 2. After release, F/D=(3,C) with no instruction lost or duplicated.
3. Redirect to 0x40 while F/D valid -> flush_dx=1 that cycle and imem_addr=0x40. Next cycle F/D is nop (fd_valid=0). The cycle after, fd_pc_out=0x41 with imem[0x40]. redirect_cnt=1, squash_cnt=2.
4. Redirect and stall asserted together -> redirect taken and stall ignored: pc_q=target next cycle, F/D nop.
5. Redirects on 2 consecutive cycles to 0x10 then 0x20 -> fetch resumes at 0x20; redirect_cnt=2; no 0x10 instruction ever reaches F/D with fd_valid=1.
6. Reset pulsed low mid-stream, plus a counter preloaded near saturation -> all outputs return to reset values immediately. Separately, redirect_cnt held at 0xFFFF stays at 0xFFFF on a further redirect.
